// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer: accepts a parallel operand pair over valid/ready
// and streams both operands out LSB-first, one bit pair per cycle, with a
// per-transaction length, downstream bubbles (stall) and back-to-back reload
// on the final bit.
module serial_operand_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [LEN_W-1:0] in_len,
   input  logic             stall,
   output logic             vld,
   output logic             a,
   output logic             b,
   output logic             last,
   output logic             busy
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [LEN_W-1:0] r_cnt;

   logic [0:0]       w_state_nxt;
   logic [WIDTH-1:0] w_sh_a_nxt;
   logic [WIDTH-1:0] w_sh_b_nxt;
   logic [LEN_W-1:0] w_cnt_nxt;

   logic [LEN_W-1:0] w_eff_len;
   logic             w_in_shift;
   logic             w_vld;
   logic             w_last;
   logic             w_ready;

   // Zero or over-range lengths fall back to the full operand width
   always_comb begin
      w_eff_len = in_len;
      if ((in_len == '0) || (in_len > LEN_MAX)) begin
         w_eff_len = LEN_MAX;
      end
   end

   // Handshake and stream qualifiers; gated by rst_n so they drop the moment reset asserts
   always_comb begin
      w_in_shift = (r_state == S_SHIFT);
      w_vld      = rst_n & w_in_shift & ~stall;
      w_last     = w_vld & (r_cnt == LEN_ONE);
      w_ready    = rst_n & (~w_in_shift | w_last);
   end

   // Next-state logic: load, shift, back-to-back reload or return to idle
   always_comb begin
      w_state_nxt = r_state;
      w_sh_a_nxt  = r_sh_a;
      w_sh_b_nxt  = r_sh_b;
      w_cnt_nxt   = r_cnt;

      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_sh_a_nxt  = in_a;
               w_sh_b_nxt  = in_b;
               w_cnt_nxt   = w_eff_len;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last) begin
               if (in_valid) begin
                  w_sh_a_nxt  = in_a;
                  w_sh_b_nxt  = in_b;
                  w_cnt_nxt   = w_eff_len;
                  w_state_nxt = S_SHIFT;
               end else begin
                  w_sh_a_nxt  = '0;
                  w_sh_b_nxt  = '0;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_IDLE;
               end
            end else if (w_vld && (r_cnt > LEN_ONE)) begin
               w_sh_a_nxt = {1'b0, r_sh_a[WIDTH-1:1]};
               w_sh_b_nxt = {1'b0, r_sh_b[WIDTH-1:1]};
               w_cnt_nxt  = r_cnt - LEN_ONE;
            end
         end
         default: begin
            w_sh_a_nxt  = '0;
            w_sh_b_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sh_a  <= '0;
         r_sh_b  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sh_a  <= w_sh_a_nxt;
         r_sh_b  <= w_sh_b_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Data bits are masked by vld so a bubble never exposes a stale pair
   assign in_ready = w_ready;
   assign vld      = w_vld;
   assign a        = w_vld & r_sh_a[0];
   assign b        = w_vld & r_sh_b[0];
   assign last     = w_last;
   assign busy     = rst_n & w_in_shift;

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer; per-cycle outputs are packed
// into bit vectors (bit i = SHIFT cycle i+1) and compared to hand-built values.
module tb_serial_operand_serializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [3:0] in_len;
   logic       stall;
   logic       vld;
   logic       a;
   logic       b;
   logic       last;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   serial_operand_serializer #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_len(in_len), .stall(stall),
      .vld(vld), .a(a), .b(b), .last(last), .busy(busy)
   );

   always #5 clk = ~clk;

   // Offer one pair while idle; returns just after the accepting edge
   task automatic load(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] len);
      in_a = va; in_b = vb; in_len = len; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Record outputs for ncyc cycles, driving stall/in_valid from per-cycle masks
   task automatic capture(input int ncyc, input logic [31:0] stall_m, input logic [31:0] valid_m,
                          output logic [31:0] v_v, output logic [31:0] a_v, output logic [31:0] b_v,
                          output logic [31:0] l_v, output logic [31:0] r_v, output logic [31:0] y_v);
      v_v = '0; a_v = '0; b_v = '0; l_v = '0; r_v = '0; y_v = '0;
      for (int c = 0; c < ncyc; c++) begin
         stall = stall_m[c]; in_valid = valid_m[c];
         @(negedge clk);
         v_v[c] = vld; a_v[c] = a; b_v[c] = b; l_v[c] = last; r_v[c] = in_ready; y_v[c] = busy;
         @(posedge clk); #1;
      end
      stall = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({in_ready, vld, a, b, last, busy} !== 6'b0)
         $display("FAIL reset_outputs got %b exp 000000", {in_ready, vld, a, b, last, busy});
      else n_pass++;
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++;
      if ({in_ready, busy, vld} !== 3'b100)
         $display("FAIL reset_release got rdy/busy/vld=%b exp 100", {in_ready, busy, vld});
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [31:0] v, av, bv, lv, rv, yv;
      load(8'h2D, 8'h13, 4'd8);
      capture(9, 32'h0, 32'h0, v, av, bv, lv, rv, yv);
      n_checks++; if (v  !== 32'h0FF) $display("FAIL basic_vld got %h exp 000000ff", v);   else n_pass++;
      n_checks++; if (av !== 32'h02D) $display("FAIL basic_a got %h exp 0000002d", av);    else n_pass++;
      n_checks++; if (bv !== 32'h013) $display("FAIL basic_b got %h exp 00000013", bv);    else n_pass++;
      n_checks++; if (lv !== 32'h080) $display("FAIL basic_last got %h exp 00000080", lv); else n_pass++;
      n_checks++; if (rv !== 32'h180) $display("FAIL basic_ready got %h exp 00000180", rv); else n_pass++;
      n_checks++; if (yv !== 32'h0FF) $display("FAIL basic_busy got %h exp 000000ff", yv); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] v, av, bv, lv, rv, yv;
      load(8'h2D, 8'h13, 4'd8);
      in_a = 8'hFF; in_b = 8'h01;
      capture(17, 32'h0, 32'h0000_00FC, v, av, bv, lv, rv, yv);
      n_checks++; if (v  !== 32'h0FFFF) $display("FAIL b2b_vld got %h exp 0000ffff", v);    else n_pass++;
      n_checks++; if (av !== 32'h0FF2D) $display("FAIL b2b_a got %h exp 0000ff2d", av);     else n_pass++;
      n_checks++; if (bv !== 32'h00113) $display("FAIL b2b_b got %h exp 00000113", bv);     else n_pass++;
      n_checks++; if (lv !== 32'h08080) $display("FAIL b2b_last got %h exp 00008080", lv);  else n_pass++;
      n_checks++; if (rv !== 32'h18080) $display("FAIL b2b_ready got %h exp 00018080", rv); else n_pass++;
      n_checks++; if (yv !== 32'h0FFFF) $display("FAIL b2b_busy got %h exp 0000ffff", yv);  else n_pass++;
   endtask

   task automatic test_length();
      logic [31:0] v, av, bv, lv, rv, yv;
      load(8'h05, 8'h03, 4'd3);
      capture(4, 32'h0, 32'h0, v, av, bv, lv, rv, yv);
      n_checks++; if (v  !== 32'h7) $display("FAIL len3_vld got %h exp 00000007", v);   else n_pass++;
      n_checks++; if (av !== 32'h5) $display("FAIL len3_a got %h exp 00000005", av);    else n_pass++;
      n_checks++; if (bv !== 32'h3) $display("FAIL len3_b got %h exp 00000003", bv);    else n_pass++;
      n_checks++; if (lv !== 32'h4) $display("FAIL len3_last got %h exp 00000004", lv); else n_pass++;
      n_checks++; if (rv !== 32'hC) $display("FAIL len3_ready got %h exp 0000000c", rv); else n_pass++;

      load(8'h2D, 8'h13, 4'd0);
      capture(9, 32'h0, 32'h0, v, av, bv, lv, rv, yv);
      n_checks++; if (v  !== 32'h0FF) $display("FAIL len0_vld got %h exp 000000ff", v);   else n_pass++;
      n_checks++; if (lv !== 32'h080) $display("FAIL len0_last got %h exp 00000080", lv); else n_pass++;

      load(8'h2D, 8'h13, 4'd12);
      capture(9, 32'h0, 32'h0, v, av, bv, lv, rv, yv);
      n_checks++; if (v  !== 32'h0FF) $display("FAIL len12_vld got %h exp 000000ff", v);   else n_pass++;
      n_checks++; if (av !== 32'h02D) $display("FAIL len12_a got %h exp 0000002d", av);    else n_pass++;
      n_checks++; if (lv !== 32'h080) $display("FAIL len12_last got %h exp 00000080", lv); else n_pass++;

      load(8'h01, 8'h00, 4'd1);
      capture(2, 32'h0, 32'h0, v, av, bv, lv, rv, yv);
      n_checks++; if (v  !== 32'h1) $display("FAIL len1_vld got %h exp 00000001", v);    else n_pass++;
      n_checks++; if (lv !== 32'h1) $display("FAIL len1_last got %h exp 00000001", lv);  else n_pass++;
      n_checks++; if (rv !== 32'h3) $display("FAIL len1_ready got %h exp 00000003", rv); else n_pass++;
      n_checks++; if (av !== 32'h1) $display("FAIL len1_a got %h exp 00000001", av);     else n_pass++;
   endtask

   task automatic test_stall();
      logic [31:0] v, av, bv, lv, rv, yv;
      stall = 1'b1; #1;
      n_checks++;
      if ({in_ready, vld, busy} !== 3'b100)
         $display("FAIL stall_idle got rdy/vld/busy=%b exp 100", {in_ready, vld, busy});
      else n_pass++;
      load(8'h2D, 8'h13, 4'd8);
      capture(11, 32'h0000_0006, 32'h0, v, av, bv, lv, rv, yv);
      n_checks++; if (v  !== 32'h3F9) $display("FAIL stall_vld got %h exp 000003f9", v);   else n_pass++;
      n_checks++; if (av !== 32'h0B1) $display("FAIL stall_a got %h exp 000000b1", av);    else n_pass++;
      n_checks++; if (bv !== 32'h049) $display("FAIL stall_b got %h exp 00000049", bv);    else n_pass++;
      n_checks++; if (lv !== 32'h200) $display("FAIL stall_last got %h exp 00000200", lv); else n_pass++;
      n_checks++; if (yv !== 32'h3FF) $display("FAIL stall_busy got %h exp 000003ff", yv); else n_pass++;
      n_checks++; if (rv !== 32'h600) $display("FAIL stall_ready got %h exp 00000600", rv); else n_pass++;
   endtask

   task automatic test_reset_midop();
      logic [31:0] v, av, bv, lv, rv, yv;
      load(8'h2D, 8'h13, 4'd8);
      capture(4, 32'h0, 32'h0, v, av, bv, lv, rv, yv);
      n_checks++;
      if ({vld, busy} !== 2'b11) $display("FAIL midop_active got vld/busy=%b exp 11", {vld, busy});
      else n_pass++;
      rst_n = 1'b0; #1;
      n_checks++;
      if ({in_ready, vld, a, b, last, busy} !== 6'b0)
         $display("FAIL midop_async got %b exp 000000", {in_ready, vld, a, b, last, busy});
      else n_pass++;
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++;
      if ({in_ready, busy} !== 2'b10) $display("FAIL midop_release got rdy/busy=%b exp 10", {in_ready, busy});
      else n_pass++;
      @(posedge clk); #1;
      load(8'h0F, 8'h00, 4'd8);
      capture(9, 32'h0, 32'h0, v, av, bv, lv, rv, yv);
      n_checks++; if (v  !== 32'h0FF) $display("FAIL midop_vld got %h exp 000000ff", v);   else n_pass++;
      n_checks++; if (av !== 32'h00F) $display("FAIL midop_a got %h exp 0000000f", av);    else n_pass++;
      n_checks++; if (bv !== 32'h000) $display("FAIL midop_b got %h exp 00000000", bv);    else n_pass++;
      n_checks++; if (lv !== 32'h080) $display("FAIL midop_last got %h exp 00000080", lv); else n_pass++;
   endtask

   // Bench-side serial adder with valid: sums on vld, clears carry after last
   task automatic test_integration();
      logic [31:0] v, av, bv, lv, rv, yv;
      logic        c, s;
      logic [7:0]  w;
      logic [7:0]  sums [2];
      int          k, nw;
      load(8'hFF, 8'h01, 4'd8);
      in_a = 8'h2D; in_b = 8'h13;
      capture(17, 32'h0, 32'h0000_00FF, v, av, bv, lv, rv, yv);
      c = 1'b0; w = '0; k = 0; nw = 0; sums[0] = 'x; sums[1] = 'x;
      for (int i = 0; i < 17; i++) begin
         if (v[i]) begin
            s = av[i] ^ bv[i] ^ c;
            if (k < 8) w[k] = s;
            k++;
            if (lv[i]) begin
               if (nw < 2) sums[nw] = w;
               nw++; k = 0; w = '0; c = 1'b0;
            end else begin
               c = (av[i] & bv[i]) | (av[i] & c) | (bv[i] & c);
            end
         end
      end
      n_checks++; if (nw !== 2) $display("FAIL integ_count got %0d exp 2", nw); else n_pass++;
      n_checks++; if (sums[0] !== 8'h00) $display("FAIL integ_ff_01 got %h exp 00", sums[0]); else n_pass++;
      n_checks++; if (sums[1] !== 8'h40) $display("FAIL integ_2d_13 got %h exp 40", sums[1]); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_len = '0; stall = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_length();
      test_stall();
      test_reset_midop();
      test_integration();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
Upstream feeder for the serial adder with valid (signals vld, a, b, last).
- Accepts a pair of parallel operands via a valid/ready handshake.
- Shifts both operands out LSB-first, one bit pair per cycle, asserting `last` on the final bit.
- Supports a per-transaction operand length and downstream bubble insertion (`stall`), so the adder's handling of vld gaps and last-triggered carry clear is exercised by real traffic.

Parameters:
- WIDTH, 8, maximum operand width in bits (>= 2).
- LEN_W, $clog2(WIDTH+1), width of the length field.

Ports:
- clk     input   1       clock; all state updates on posedge.
- rst_n   input   1       asynchronous active-low reset.
- in_valid input  1       operand pair offered.
- in_ready output 1       block can accept an operand pair this cycle.
- in_a    input   WIDTH   operand A, bit 0 sent first.
- in_b    input   WIDTH   operand B, bit 0 sent first.
- in_len  input   LEN_W   bits to send; 0 or > WIDTH means WIDTH.
- stall   input   1       downstream requests a bubble this cycle.
- vld     output  1       a/b carry a valid bit pair.
- a       output  1       current bit of A.
- b       output  1       current bit of B.
- last    output  1       current bit pair is the final one of the transaction.
- busy    output  1       transaction in progress (state SHIFT).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state:
  - While rst_n low: state=IDLE, shift regs=0, counter=0.
  - All outputs 0, including in_ready=0.
  - Outputs go low immediately on rst_n falling, without waiting for a clock edge.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - in_ready=1 (when rst_n high); vld=a=b=last=0; busy=0.
  - On posedge with in_valid=1: load sh_a<=in_a, sh_b<=in_b, cnt<=eff_len; go to SHIFT.
  - eff_len = (in_len==0 || in_len>WIDTH) ? WIDTH : in_len.
- SHIFT:
  - busy=1.
  - Combinational outputs:
    - vld = ~stall.
    - a = vld & sh_a[0].
    - b = vld & sh_b[0].
    - last = vld & (cnt==1).
  - On posedge with vld=1 and cnt>1: shift both regs right by 1 (zero fill), cnt<=cnt-1.
  - On posedge with stall=1: no state change; the same bit pair is presented again when stall drops.
  - in_ready = last (a new pair is accepted only on the final-bit cycle).
  - On posedge with last=1:
    - If in_valid=1: reload regs and cnt from the new operands, stay in SHIFT. Transactions run back-to-back with no bubble.
    - Otherwise: go to IDLE, clear regs.
- Latency: operand accepted at edge k; first bit pair is visible (vld=1 unless stalled) in the cycle after edge k.
- Throughput: one bit per non-stalled cycle. Total cycles per transaction = eff_len + number of stalled SHIFT cycles.
- Outputs a/b/last are forced to 0 whenever vld=0, so downstream never sees stale data.
- stall in IDLE has no effect.
- in_valid while busy and not on the last cycle is not accepted. The upstream must hold its data, per valid/ready rules.
- eff_len=1: single cycle with vld=last=1; in_ready=1 in that same cycle.
- Reset mid-transaction: the transaction is abandoned with no partial `last`. After rst_n rises the block is in IDLE with in_ready=1.

Test Plan:
1. Basic: WIDTH=8, in_a=0x2D, in_b=0x13, in_len=8, no stall.
   - 8 consecutive vld cycles.
   - a bits 1,0,1,1,0,1,0,0; b bits 1,1,0,0,1,0,0,0.
   - last only on cycle 8; in_ready=0 on cycles 1-7, 1 on cycle 8; then IDLE with busy=0.
2. Back-to-back: second pair 0xFF/0x01 held valid from cycle 3 of test 1.
   - Accepted at cycle 8; vld continuous for 16 cycles.
   - last at cycles 8 and 16; second stream a all 1s, b = 1 then 0s.
3. Length handling:
   - in_len=3 with 0x05/0x03 -> a 1,0,1; b 1,1,0; last on 3rd.
   - in_len=0 -> 8 bits; in_len=12 -> 8 bits.
   - in_len=1 -> one cycle with vld=last=1.
4. Stall: stall high on SHIFT cycles 2 and 3 of test 1.
   - vld=a=b=0 on those cycles; bit 1 re-presented afterwards.
   - Transaction lasts 10 cycles; exactly 8 vld pulses and one last.
5. Reset mid-op: drop rst_n after 4 bits sent.
   - vld/busy/last fall immediately, before the next edge.
   - After release: in_ready=1; a new 0x0F/0x00 transaction starts from bit 0.
6. Integration: chain into the serial adder with valid.
   - 0x2D+0x13 sum bits LSB-first = 0x40.
   - 0xFF+0x01 = 0x00 (mod 2^8); carry does not leak into the next back-to-back transaction.
